// File: rtl/sync_width_fifo.sv
// Single-clock FIFO with write/read width conversion. Storage and occupancy are in
// narrow units; the wide side packs or unpacks lanes little-endian (unit 0 = bits [NW-1:0]).
module sync_width_fifo #(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 32,
  parameter int AW        = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr,
  input  logic [IN_W-1:0]  i_wdata,
  output logic             o_wfull,
  output logic             o_walmost_full,
  output logic             o_wovf,
  input  logic             i_rd,
  output logic [OUT_W-1:0] o_rdata,
  output logic             o_rvalid,
  output logic             o_rempty,
  output logic             o_ralmost_empty,
  output logic             o_runf,
  output logic [AW:0]      o_count
);

  localparam int NW    = (IN_W < OUT_W) ? IN_W : OUT_W;
  localparam int IN_U  = IN_W / NW;
  localparam int OUT_U = OUT_W / NW;
  localparam int DEPTH = 1 << AW;

  localparam logic [AW:0] IN_INC   = (AW+1)'(IN_U);
  localparam logic [AW:0] OUT_DEC  = (AW+1)'(OUT_U);
  localparam logic [AW:0] FULL_LIM = (AW+1)'(DEPTH - IN_U);
  localparam logic [AW:0] AF_LIM   = (AW+1)'(AFULL_TH);
  localparam logic [AW:0] AE_LIM   = (AW+1)'(AEMPTY_TH);

  // Flat narrow-unit array: the low log2(RATIO) address bits select the bank, the rest the row.
  logic [NW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [AW:0]   count;
  logic          wr_ok;
  logic          rd_ok;

  assign o_count         = count;
  assign o_wfull         = (count > FULL_LIM);
  assign o_walmost_full  = (count >= AF_LIM);
  assign o_rempty        = (count < OUT_DEC);
  assign o_ralmost_empty = (count <= AE_LIM);

  assign wr_ok = i_wr & ~o_wfull;
  assign rd_ok = i_rd & ~o_rempty;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      o_rdata  <= '0;
      o_rvalid <= 1'b0;
      o_wovf   <= 1'b0;
      o_runf   <= 1'b0;
    end else begin
      if (wr_ok) wptr <= wptr + AW'(IN_U);
      if (rd_ok) rptr <= rptr + AW'(OUT_U);
      count    <= count + (wr_ok ? IN_INC : '0) - (rd_ok ? OUT_DEC : '0);
      o_rvalid <= rd_ok;
      o_wovf   <= i_wr & o_wfull;
      o_runf   <= i_rd & o_rempty;
      if (rd_ok) begin
        for (int k = 0; k < OUT_U; k++) begin
          o_rdata[k*NW +: NW] <= mem[rptr + AW'(k)];
        end
      end
    end
  end

  // Contents need no reset: pointers and count define what is valid.
  always_ff @(posedge i_clk) begin
    if (wr_ok && !i_rst) begin
      for (int k = 0; k < IN_U; k++) begin
        mem[wptr + AW'(k)] <= i_wdata[k*NW +: NW];
      end
    end
  end

endmodule

// File: tb/tb_sync_width_fifo.sv
// Bench for sync_width_fifo: an 8->32 upsizer and a 32->8 downsizer against a byte-queue model.
module tb_sync_width_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        a_wr, a_rd, a_wfull, a_walmost_full, a_wovf, a_rvalid, a_rempty, a_ralmost_empty, a_runf;
  logic [7:0]  a_wdata;
  logic [31:0] a_rdata;
  logic [4:0]  a_count;

  logic        b_wr, b_rd, b_wfull, b_walmost_full, b_wovf, b_rvalid, b_rempty, b_ralmost_empty, b_runf;
  logic [31:0] b_wdata;
  logic [7:0]  b_rdata;
  logic [4:0]  b_count;

  sync_width_fifo #(.IN_W(8), .OUT_W(32), .AW(4), .AFULL_TH(12), .AEMPTY_TH(4)) dut_up (
    .i_clk(clk), .i_rst(rst), .i_wr(a_wr), .i_wdata(a_wdata),
    .o_wfull(a_wfull), .o_walmost_full(a_walmost_full), .o_wovf(a_wovf),
    .i_rd(a_rd), .o_rdata(a_rdata), .o_rvalid(a_rvalid), .o_rempty(a_rempty),
    .o_ralmost_empty(a_ralmost_empty), .o_runf(a_runf), .o_count(a_count)
  );

  sync_width_fifo #(.IN_W(32), .OUT_W(8), .AW(4), .AFULL_TH(12), .AEMPTY_TH(4)) dut_dn (
    .i_clk(clk), .i_rst(rst), .i_wr(b_wr), .i_wdata(b_wdata),
    .o_wfull(b_wfull), .o_walmost_full(b_walmost_full), .o_wovf(b_wovf),
    .i_rd(b_rd), .o_rdata(b_rdata), .o_rvalid(b_rvalid), .o_rempty(b_rempty),
    .o_ralmost_empty(b_ralmost_empty), .o_runf(b_runf), .o_count(b_count)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: occupancy is simply the number of bytes held in a queue.
  logic [7:0]  qa[$];
  logic [7:0]  qb[$];
  logic [31:0] ea_rdata;
  logic [7:0]  eb_rdata;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_flags_a();
    int n = qa.size();
    check("a_count", 64'(a_count), 64'(n));
    check("a_rempty", 64'(a_rempty), 64'(n < 4));
    check("a_wfull", 64'(a_wfull), 64'(n > 15));
    check("a_walmost_full", 64'(a_walmost_full), 64'(n >= 12));
    check("a_ralmost_empty", 64'(a_ralmost_empty), 64'(n <= 4));
  endtask

  task automatic check_flags_b();
    int n = qb.size();
    check("b_count", 64'(b_count), 64'(n));
    check("b_rempty", 64'(b_rempty), 64'(n < 1));
    check("b_wfull", 64'(b_wfull), 64'(n > 12));
    check("b_walmost_full", 64'(b_walmost_full), 64'(n >= 12));
    check("b_ralmost_empty", 64'(b_ralmost_empty), 64'(n <= 4));
  endtask

  task automatic step_a(input logic wr, input logic [7:0] wd, input logic rd);
    int  n   = qa.size();
    bit  wf  = (n > 15);
    bit  re  = (n < 4);
    bit  wok = wr && !wf;
    bit  rok = rd && !re;
    a_wr = wr; a_wdata = wd; a_rd = rd;
    @(posedge clk);
    #1;
    a_wr = 1'b0; a_rd = 1'b0;
    if (rok) for (int k = 0; k < 4; k++) ea_rdata[k*8 +: 8] = qa.pop_front();
    if (wok) qa.push_back(wd);
    check("a_rvalid", 64'(a_rvalid), 64'(rok));
    check("a_rdata", 64'(a_rdata), 64'(ea_rdata));
    check("a_wovf", 64'(a_wovf), 64'(wr && wf));
    check("a_runf", 64'(a_runf), 64'(rd && re));
    check_flags_a();
  endtask

  task automatic step_b(input logic wr, input logic [31:0] wd, input logic rd);
    int  n   = qb.size();
    bit  wf  = (n > 12);
    bit  re  = (n < 1);
    bit  wok = wr && !wf;
    bit  rok = rd && !re;
    b_wr = wr; b_wdata = wd; b_rd = rd;
    @(posedge clk);
    #1;
    b_wr = 1'b0; b_rd = 1'b0;
    if (rok) eb_rdata = qb.pop_front();
    if (wok) for (int k = 0; k < 4; k++) qb.push_back(wd[k*8 +: 8]);
    check("b_rvalid", 64'(b_rvalid), 64'(rok));
    check("b_rdata", 64'(b_rdata), 64'(eb_rdata));
    check("b_wovf", 64'(b_wovf), 64'(wr && wf));
    check("b_runf", 64'(b_runf), 64'(rd && re));
    check_flags_b();
  endtask

  // Asynchronous reset with requests held high: nothing may be accepted meanwhile.
  task automatic do_reset();
    rst = 1'b1;
    a_wr = 1'b1; a_rd = 1'b1; a_wdata = 8'h5A;
    b_wr = 1'b1; b_rd = 1'b1; b_wdata = 32'h5A5A5A5A;
    #2;
    qa.delete(); qb.delete();
    ea_rdata = '0; eb_rdata = '0;
    check("rst_a_rdata", 64'(a_rdata), 64'h0);
    check("rst_a_pulses", 64'({a_rvalid, a_wovf, a_runf}), 64'h0);
    check("rst_b_rdata", 64'(b_rdata), 64'h0);
    check("rst_b_pulses", 64'({b_rvalid, b_wovf, b_runf}), 64'h0);
    check_flags_a();
    check_flags_b();
    @(posedge clk);
    #1;
    check("rst_hold_a_count", 64'(a_count), 64'h0);
    check("rst_hold_b_count", 64'(b_count), 64'h0);
    rst = 1'b0;
    a_wr = 1'b0; a_rd = 1'b0; b_wr = 1'b0; b_rd = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    int written;
    int cyc;
    logic wr;
    logic rd;
    rst = 1'b1;
    a_wr = 1'b0; a_rd = 1'b0; a_wdata = '0;
    b_wr = 1'b0; b_rd = 1'b0; b_wdata = '0;
    ea_rdata = '0; eb_rdata = '0;
    #3;
    do_reset();

    // Reset mid-stream.
    step_a(1, 8'hAA, 0);
    step_a(1, 8'hBB, 0);
    step_b(1, 32'h01020304, 0);
    do_reset();

    // Partial word invisible until four bytes are present.
    step_a(1, 8'h11, 0);
    step_a(1, 8'h22, 0);
    step_a(1, 8'h33, 0);
    check("t2_rempty3", 64'(a_rempty), 64'h1);
    step_a(1, 8'h44, 0);
    check("t2_rempty4", 64'(a_rempty), 64'h0);
    step_a(0, 8'h00, 1);
    check("t2_word", 64'(a_rdata), 64'h44332211);
    check("t2_count", 64'(a_count), 64'h0);

    // Fill to full, then overflow.
    for (int i = 0; i < 16; i++) step_a(1, 8'(8'h80 + i), 0);
    check("t3_full", 64'(a_wfull), 64'h1);
    step_a(1, 8'hEE, 0);
    check("t3_ovf", 64'(a_wovf), 64'h1);
    check("t3_count", 64'(a_count), 64'd16);
    for (int i = 0; i < 4; i++) step_a(0, 8'h00, 1);
    check("t3_last_word", 64'(a_rdata), 64'h8F8E8D8C);

    // Underflow, then simultaneous write and read at exactly one word.
    step_a(0, 8'h00, 1);
    check("t4_unf", 64'(a_runf), 64'h1);
    for (int i = 0; i < 4; i++) step_a(1, 8'(8'hC0 + i), 0);
    step_a(1, 8'hD7, 1);
    check("t4_count", 64'(a_count), 64'h1);
    check("t4_word", 64'(a_rdata), 64'hC3C2C1C0);
    step_a(1, 8'hD8, 0);
    step_a(1, 8'hD9, 0);
    step_a(1, 8'hDA, 0);
    step_a(0, 8'h00, 1);
    check("t4_word2", 64'(a_rdata), 64'hDAD9D8D7);

    // Random stream of 64 bytes with a well-behaved producer and consumer.
    written = 0;
    cyc = 0;
    while (written < 64 && cyc < 2000) begin
      wr = ($urandom_range(0, 2) != 0) && (qa.size() < 16);
      rd = ($urandom_range(0, 2) == 0) && (qa.size() >= 4);
      step_a(wr, 8'($urandom), rd);
      if (wr) written++;
      cyc++;
    end
    check("t5_written", 64'(written), 64'd64);
    cyc = 0;
    while (qa.size() >= 4 && cyc < 100) begin
      step_a(0, 8'h00, 1);
      cyc++;
    end
    check("t5_drained", 64'(a_rempty), 64'h1);

    // Downsizer.
    step_b(1, 32'hA1B2C3D4, 0);
    check("t6_count", 64'(b_count), 64'd4);
    step_b(0, 32'h0, 1);
    check("t6_b0", 64'(b_rdata), 64'hD4);
    step_b(0, 32'h0, 1);
    check("t6_b1", 64'(b_rdata), 64'hC3);
    step_b(0, 32'h0, 1);
    check("t6_b2", 64'(b_rdata), 64'hB2);
    step_b(0, 32'h0, 1);
    check("t6_b3", 64'(b_rdata), 64'hA1);
    check("t6_empty", 64'(b_rempty), 64'h1);

    // Unconstrained random traffic on the downsizer, including illegal requests.
    for (int i = 0; i < 120; i++) begin
      step_b(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 2) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
